// File: rtl/trig_pkg.sv
// Shared constants and state type for the trigger-board monitoring readout.
package trig_pkg;
  localparam logic [15:0] HDR_MAGIC = 16'hB0A0;
  localparam int NCHAN_DEF = 16;
  localparam int NHIST_DEF = 8;

  typedef enum logic [2:0] {IDLE, HDR, SEL, CAP, SEND, CLR, END} ro_state_t;
endpackage

// File: rtl/histo_readout_sequencer.sv
// Steps the histogram mux through all channels, snapshots each channel and streams
// a header plus every word to the slow-control link, optionally clearing afterwards.
//  state | meaning
//  IDLE  | waiting for start
//  HDR   | presenting frame header
//  SEL   | channel select driven, waiting for mux to settle
//  CAP   | snapshot histo_in into shadow registers
//  SEND  | streaming shadow words of current channel
//  CLR   | holding resethist high
//  END   | bump frame count, release busy
module histo_readout_sequencer
  import trig_pkg::*;
#(
  parameter int NCHAN   = NCHAN_DEF,
  parameter int NHIST   = NHIST_DEF,
  parameter int WORD_W  = 32,
  parameter int SETTLE  = 3,
  parameter int CLR_CYC = 2
) (
  input  logic                    clk_adc,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    clear_after,
  input  logic [NHIST*WORD_W-1:0] histo_in,
  output logic [7:0]              histo_sel,
  output logic                    resethist,
  output logic [WORD_W-1:0]       m_data,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic                    busy,
  output logic [15:0]             frame_cnt
);

  localparam int CH_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int H_W  = (NHIST > 1) ? $clog2(NHIST) : 1;

  ro_state_t         state;
  logic [CH_W-1:0]   ch;
  logic [H_W-1:0]    h;
  logic [7:0]        settle_cnt;
  logic [7:0]        clr_cnt;
  logic              clr_pending;
  logic [WORD_W-1:0] shadow [NHIST];
  logic              xfer;
  logic              last_ch;
  logic              last_h;

  assign xfer    = m_valid && m_ready;
  assign last_ch = (ch == CH_W'(NCHAN - 1));
  assign last_h  = (h == H_W'(NHIST - 1));

  // Shadow only loads in CAP, so a channel's words stay frozen until it is fully sent.
  always_ff @(posedge clk_adc) begin
    if (state == CAP) begin
      for (int i = 0; i < NHIST; i++) shadow[i] <= histo_in[i*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk_adc) begin
    if (rst) begin
      state       <= IDLE;
      ch          <= '0;
      h           <= '0;
      settle_cnt  <= '0;
      clr_cnt     <= '0;
      clr_pending <= 1'b0;
      histo_sel   <= '0;
      resethist   <= 1'b0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            clr_pending <= clear_after;
            ch          <= '0;
            busy        <= 1'b1;
            m_data      <= WORD_W'({HDR_MAGIC, frame_cnt});
            m_valid     <= 1'b1;
            m_last      <= 1'b0;
            state       <= HDR;
          end
        end
        HDR: begin
          if (xfer) begin
            m_valid    <= 1'b0;
            histo_sel  <= 8'(ch);
            settle_cnt <= 8'(SETTLE);
            state      <= SEL;
          end
        end
        SEL: begin
          if (settle_cnt <= 8'd1) state <= CAP;
          else settle_cnt <= settle_cnt - 8'd1;
        end
        CAP: begin
          h       <= '0;
          m_data  <= histo_in[WORD_W-1:0];
          m_valid <= 1'b1;
          m_last  <= last_ch && (NHIST == 1);
          state   <= SEND;
        end
        SEND: begin
          if (xfer) begin
            if (!last_h) begin
              h      <= h + H_W'(1);
              m_data <= shadow[h + H_W'(1)];
              m_last <= last_ch && (int'(h) + 2 == NHIST);
            end else begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              if (!last_ch) begin
                ch         <= ch + CH_W'(1);
                histo_sel  <= 8'(ch + CH_W'(1));
                settle_cnt <= 8'(SETTLE);
                state      <= SEL;
              end else if (clr_pending) begin
                resethist <= 1'b1;
                clr_cnt   <= 8'(CLR_CYC);
                state     <= CLR;
              end else begin
                state <= END;
              end
            end
          end
        end
        CLR: begin
          if (clr_cnt <= 8'd1) begin
            resethist <= 1'b0;
            state     <= END;
          end else begin
            clr_cnt <= clr_cnt - 8'd1;
          end
        end
        END: begin
          frame_cnt <= frame_cnt + 16'd1;
          busy      <= 1'b0;
          histo_sel <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_histo_readout_sequencer.sv
// Scoreboard bench: expected frames are queued at start, a monitor checks every transfer.
module tb_histo_readout_sequencer;
  import trig_pkg::*;

  localparam int NCHAN  = 16;
  localparam int NHIST  = 8;
  localparam int WORD_W = 32;

  logic                    clk_adc = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic                    clear_after = 1'b0;
  logic [NHIST*WORD_W-1:0] histo_in;
  logic [7:0]              histo_sel;
  logic                    resethist;
  logic [WORD_W-1:0]       m_data;
  logic                    m_valid;
  logic                    m_last;
  logic                    m_ready = 1'b1;
  logic                    busy;
  logic [15:0]             frame_cnt;

  histo_readout_sequencer #(.NCHAN(NCHAN), .NHIST(NHIST), .WORD_W(WORD_W)) dut (
    .clk_adc(clk_adc), .rst(rst), .start(start), .clear_after(clear_after),
    .histo_in(histo_in), .histo_sel(histo_sel), .resethist(resethist),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk_adc = ~clk_adc;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          frame_words = 0;
  bit          last_seen = 0;
  bit          rand_ready = 0;
  logic [15:0] salt = '0;
  logic [15:0] fc_model = '0;
  logic [7:0]  sel_d1 = '0, sel_d2 = '0;
  logic [31:0] junk = '0;

  function automatic logic [31:0] word_of(int c, int hh, logic [15:0] s);
    return {s, 8'(c), 8'(hh)};
  endfunction

  // Histogram mux model: two-cycle registered path, garbage while a select change is in flight.
  always @(posedge clk_adc) begin
    sel_d1 <= histo_sel;
    sel_d2 <= sel_d1;
    junk   <= $urandom;
  end

  always_comb begin
    histo_in = '0;
    for (int i = 0; i < NHIST; i++) begin
      if (sel_d1 == sel_d2) histo_in[i*WORD_W +: WORD_W] = word_of(int'(sel_d2), i, salt);
      else histo_in[i*WORD_W +: WORD_W] = junk ^ 32'(i);
    end
  end

  always @(posedge clk_adc) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  bit          hold_pending = 0;
  logic [31:0] hold_data;
  logic        hold_last;

  always @(negedge clk_adc) begin
    exp_t e;
    if (rst) begin
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        checks++;
        if (!(m_valid && m_data === hold_data && m_last === hold_last)) begin
          errors++;
          $display("FAIL hold_stable: valid=%0b data=%08h last=%0b, required valid=1 data=%08h last=%0b",
                   m_valid, m_data, m_last, hold_data, hold_last);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: data=%08h last=%0b, required no transfer", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e.d || m_last !== e.l) begin
            errors++;
            $display("FAIL stream_word %0d: data=%08h last=%0b, required data=%08h last=%0b",
                     frame_words, m_data, m_last, e.d, e.l);
          end
        end
        frame_words++;
        if (m_last) last_seen = 1;
      end
      hold_pending = m_valid && !m_ready;
      hold_data    = m_data;
      hold_last    = m_last;
    end
  end

  task automatic tick();
    @(posedge clk_adc);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_frame();
    exp_q.push_back('{d: {HDR_MAGIC, fc_model}, l: 1'b0});
    for (int c = 0; c < NCHAN; c++)
      for (int hh = 0; hh < NHIST; hh++)
        exp_q.push_back('{d: word_of(c, hh, salt), l: (c == NCHAN - 1 && hh == NHIST - 1)});
  endtask

  task automatic check_reset_state();
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_histo_sel", 64'(histo_sel), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_resethist", 64'(resethist), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
  endtask

  task automatic run_frame(input logic clr, input bit rnd, input logic [15:0] s, input bit restart_mid);
    int  k;
    int  rh;
    bit  pulsed;
    salt        = s;
    rand_ready  = rnd;
    frame_words = 0;
    last_seen   = 0;
    push_frame();
    clear_after = clr;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    clear_after = 1'b0;
    chk("start_latency_valid", 64'(m_valid), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
    k = 0;
    pulsed = 0;
    while (!last_seen && k < 5000) begin
      if (restart_mid && !pulsed && frame_words >= 40) begin
        start  = 1'b1;
        pulsed = 1;
      end
      tick();
      start = 1'b0;
      k++;
    end
    if (!last_seen) chk("frame_timeout", 64'd1, 64'd0);
    rh = 0;
    k  = 0;
    while (busy && k < 20) begin
      if (resethist) rh++;
      tick();
      k++;
    end
    fc_model = fc_model + 16'd1;
    chk("resethist_cycles", 64'(rh), clr ? 64'd2 : 64'd0);
    chk("tail_cycles", 64'(k), clr ? 64'd3 : 64'd1);
    chk("frame_cnt", 64'(frame_cnt), 64'(fc_model));
    chk("words_left", 64'(exp_q.size()), 64'd0);
    chk("frame_words", 64'(frame_words), 64'(1 + NCHAN * NHIST));
    repeat (3) tick();
    chk("idle_after_frame", 64'(busy), 64'd0);
    chk("frame_cnt_stable", 64'(frame_cnt), 64'(fc_model));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_state();

    run_frame(1'b0, 1'b0, 16'h0000, 1'b0);
    run_frame(1'b0, 1'b1, 16'($urandom), 1'b0);
    run_frame(1'b1, 1'b1, 16'($urandom), 1'b0);
    run_frame(1'b1, 1'b0, 16'($urandom), 1'b0);
    run_frame(1'b0, 1'b1, 16'($urandom), 1'b1);

    // Reset in the middle of channel 5, with start asserted alongside it.
    salt        = 16'($urandom);
    rand_ready  = 1;
    frame_words = 0;
    last_seen   = 0;
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(histo_sel == 8'd5 && m_valid) && k < 5000) begin
      tick();
      k++;
    end
    chk("reach_ch5", 64'(histo_sel), 64'd5);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check_reset_state();
    chk("no_partial_last", 64'(last_seen), 64'd0);
    exp_q.delete();
    fc_model = '0;
    repeat (2) tick();
    chk("rst_start_ignored", 64'(busy), 64'd0);

    run_frame(1'b0, 1'b1, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
